// File: rtl/loopback_interceptor.sv
// loopback_interceptor: diverts self-addressed sends into a loopback FIFO and
// merges them with network receives through a fair two-way arbiter.
module loopback_interceptor #(
    parameter int LOOPBACK_DEPTH = 2,
    parameter int ADDR_W = 8,
    parameter int TAG_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              local_address,
    input  logic                           core_interceptor_valid,
    output logic                           interceptor_core_ready,
    input  logic [ADDR_W+TAG_W+DATA_W-1:0] core_interceptor_data,
    output logic                           loopback_interface_valid,
    input  logic                           interface_loopback_ready,
    output logic [ADDR_W+TAG_W+DATA_W-1:0] loopback_interface_data,
    input  logic                           interface_loopback_valid,
    output logic                           loopback_interface_ready,
    input  logic [ADDR_W+TAG_W+DATA_W-1:0] interface_loopback_data,
    output logic                           interceptor_core_valid,
    input  logic                           core_interceptor_ready,
    output logic [ADDR_W+TAG_W+DATA_W-1:0] interceptor_core_data
);
    localparam int MSG_W = ADDR_W + TAG_W + DATA_W;
    localparam int PTR_W = $clog2(LOOPBACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [MSG_W-1:0] mem [LOOPBACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             prio;
    logic             out_valid;
    logic [MSG_W-1:0] out_data;
    logic             is_local, full, empty, push, pop, out_free, grant_net, contested;

    assign is_local = core_interceptor_data[MSG_W-1 -: ADDR_W] == local_address;
    assign full     = count == CNT_W'(LOOPBACK_DEPTH);
    assign empty    = count == '0;
    assign push     = core_interceptor_valid && is_local && !full;
    assign out_free = !out_valid || core_interceptor_ready;

    // Network wins a contest when prio is 0; rst masks grants so nothing is acknowledged during reset.
    assign contested = out_free && interface_loopback_valid && !empty;
    assign grant_net = !rst && out_free && interface_loopback_valid && (empty || !prio);
    assign pop       = !rst && out_free && !empty && (!interface_loopback_valid || prio);

    assign loopback_interface_valid = core_interceptor_valid && !is_local;
    assign loopback_interface_data  = core_interceptor_data;
    assign interceptor_core_ready   = is_local ? !full : interface_loopback_ready;
    assign loopback_interface_ready = grant_net;
    assign interceptor_core_valid   = out_valid;
    assign interceptor_core_data    = out_data;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {local_address, core_interceptor_data[TAG_W+DATA_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push) - CNT_W'(pop);
            if (contested) prio <= !prio;
            if (grant_net) begin
                out_valid <= 1'b1;
                out_data  <= interface_loopback_data;
            end else if (pop) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
            end else if (core_interceptor_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_loopback_interceptor.sv
// tb_loopback_interceptor: directed vectors for pass-through, loopback, backpressure,
// arbitration fairness and asynchronous reset of loopback_interceptor.
module tb_loopback_interceptor;
    localparam int MSG_W = 44;

    logic             clk = 0;
    logic             rst;
    logic [7:0]       local_address;
    logic             civ, icr, liv, lir, ifl_valid, lif_ready, icv, core_rx_ready;
    logic [MSG_W-1:0] cid, lid, ifl_data, icd;
    int               checks = 0;
    int               errors = 0;

    loopback_interceptor #(.LOOPBACK_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .local_address(local_address),
        .core_interceptor_valid(civ), .interceptor_core_ready(icr), .core_interceptor_data(cid),
        .loopback_interface_valid(liv), .interface_loopback_ready(lif_ready), .loopback_interface_data(lid),
        .interface_loopback_valid(ifl_valid), .loopback_interface_ready(lir), .interface_loopback_data(ifl_data),
        .interceptor_core_valid(icv), .core_interceptor_ready(core_rx_ready), .interceptor_core_data(icd)
    );

    always #5 clk = ~clk;

    function automatic logic [MSG_W-1:0] mk(input logic [7:0] a, input logic [3:0] t, input logic [31:0] d);
        return {a, t, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [MSG_W-1:0] exp_seq [5];
    logic             exp_lir [5];
    int               n;

    initial begin
        rst = 1; local_address = 8'd5;
        civ = 1; cid = mk(3, 1, 32'h11); lif_ready = 1;
        ifl_valid = 1; ifl_data = mk(9, 0, 32'hDEAD); core_rx_ready = 1;
        #2;
        check("rst_core_valid", icv, 0);
        check("rst_lb_ready", lir, 0);
        check("rst_pass_valid", liv, 1);
        check("rst_pass_data", lid, mk(3, 1, 32'h11));
        check("rst_pass_ready", icr, 1);
        cid = mk(5, 1, 32'h11);
        #1;
        check("rst_local_ready", icr, 1);
        check("rst_local_no_fwd", liv, 0);
        civ = 0; ifl_valid = 0;
        tick;
        rst = 0;
        // remote send passes straight through
        civ = 1; cid = mk(3, 1, 32'h11); lif_ready = 1;
        #1;
        check("remote_valid", liv, 1);
        check("remote_data", lid, mk(3, 1, 32'h11));
        check("remote_ready", icr, 1);
        lif_ready = 0;
        #1;
        check("remote_ready_low", icr, 0);
        lif_ready = 1;
        tick;
        civ = 0;
        tick;
        check("remote_not_looped", icv, 0);
        // local send appears two edges later
        civ = 1; cid = mk(5, 2, 32'hAB);
        #1;
        check("local_ready", icr, 1);
        check("local_no_fwd", liv, 0);
        tick;
        civ = 0;
        check("local_lat1", icv, 0);
        tick;
        check("local_lat2_valid", icv, 1);
        check("local_lat2_data", icd, mk(5, 2, 32'hAB));
        tick;
        check("local_drained", icv, 0);
        // backpressure: four local sends with core stalled
        core_rx_ready = 0;
        civ = 1; cid = mk(5, 3, 32'h100);
        tick;
        cid = mk(5, 4, 32'h101);
        check("bp_ready1", icr, 1);
        tick;
        cid = mk(5, 5, 32'h102);
        check("bp_ready2", icr, 1);
        check("bp_out_l0", icd, mk(5, 3, 32'h100));
        tick;
        cid = mk(5, 6, 32'h103);
        #1;
        check("bp_full", icr, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_full_hold", icr, 0);
            check("bp_stable", icd, mk(5, 3, 32'h100));
            check("bp_valid_hold", icv, 1);
        end
        core_rx_ready = 1;
        tick;
        check("bp_out_l1", icd, mk(5, 4, 32'h101));
        check("bp_ready_again", icr, 1);
        tick;
        civ = 0;
        check("bp_out_l2", icd, mk(5, 5, 32'h102));
        tick;
        check("bp_out_l3", icd, mk(5, 6, 32'h103));
        tick;
        check("bp_empty", icv, 0);
        // arbitration fairness from reset
        rst = 1; #2; rst = 0;
        core_rx_ready = 0;
        civ = 1; cid = mk(5, 1, 32'h200);
        tick;
        cid = mk(5, 2, 32'h201);
        tick;
        cid = mk(5, 3, 32'h202);
        tick;
        civ = 0;
        n = 0;
        ifl_valid = 1; ifl_data = mk(9, 4'(n), 32'hA0 + n);
        core_rx_ready = 1;
        exp_seq = '{mk(9, 0, 32'hA0), mk(5, 2, 32'h201), mk(9, 1, 32'hA1), mk(5, 3, 32'h202), mk(9, 2, 32'hA2)};
        exp_lir = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("arb_lir", lir, exp_lir[i]);
            tick;
            if (exp_lir[i]) begin
                n++;
                ifl_data = mk(9, 4'(n), 32'hA0 + n);
            end
            check("arb_order", icd, exp_seq[i]);
        end
        // stall with network pending, then async reset mid-stream
        core_rx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_lir", lir, 0);
            check("stall_data", icd, mk(9, 2, 32'hA2));
            check("stall_valid", icv, 1);
            tick;
        end
        civ = 1; cid = mk(5, 7, 32'h300);
        rst = 1;
        #1;
        check("async_rst_valid", icv, 0);
        check("async_rst_lir", lir, 0);
        check("async_rst_local_ready", icr, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/loopback_interceptor.md
LOOPBACK_INTERCEPTOR -- requirements
Module: loopback_interceptor

Interface
REQ-001 SHALL have parameter LOOPBACK_DEPTH, default 2, loopback FIFO entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port local_address  input  message_addr_t  this tile's address, held stable.
REQ-005 SHALL have port core_interceptor_valid  input  1  core send request valid.
REQ-006 SHALL have port interceptor_core_ready  output  1  send request accepted.
REQ-007 SHALL have port core_interceptor_data  input  interface_send_data_t  send message, meta.address = destination.
REQ-008 SHALL have port loopback_interface_valid  output  1  send toward network adapter valid.
REQ-009 SHALL have port interface_loopback_ready  input  1  network adapter send ready.
REQ-010 SHALL have port loopback_interface_data  output  interface_send_data_t  send message to adapter.
REQ-011 SHALL have port interface_loopback_valid  input  1  received network message valid.
REQ-012 SHALL have port loopback_interface_ready  output  1  received network message accepted.
REQ-013 SHALL have port interface_loopback_data  input  interface_receive_data_t  received message, meta.address = source.
REQ-014 SHALL have port interceptor_core_valid  output  1  receive message to core valid.
REQ-015 SHALL have port core_interceptor_ready  input  1  core receive ready.
REQ-016 SHALL have port interceptor_core_data  output  interface_receive_data_t  receive message to core.

Function
REQ-017 Transfer on any channel SHALL occur in a cycle where valid and ready are both high at the rising edge.
REQ-018 Remote send (meta.address != local_address) SHALL pass through combinationally: loopback_interface_valid = core_interceptor_valid, interceptor_core_ready = interface_loopback_ready, data unchanged; zero latency.
REQ-019 Local send (meta.address == local_address) SHALL keep loopback_interface_valid low and push into the loopback FIFO; interceptor_core_ready = !fifo_full, with no same-cycle pop bypass.
REQ-020 Loopback FIFO entry SHALL store meta.address = local_address, with meta.tag and data copied from the send message.
REQ-021 FIFO SHALL use read/write pointers wrapping modulo LOOPBACK_DEPTH and an occupancy counter of width $clog2(LOOPBACK_DEPTH)+1; full = (count == LOOPBACK_DEPTH), empty = (count == 0).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pop SHALL occur only when not empty and push only when not full.
REQ-023 Receive output SHALL be a single register stage (out_valid, out_data) driving interceptor_core_valid and interceptor_core_data.
REQ-024 Output register SHALL accept a new message when !out_valid or (out_valid and core_interceptor_ready).
REQ-025 Arbiter SHALL choose between network (interface_loopback_valid) and FIFO head (!empty) only when REQ-024 holds; with one candidate, that candidate is granted.
REQ-026 With both candidates valid, grant SHALL go to the side indicated by priority bit prio (0 = network, 1 = loopback); prio SHALL flip to the other side after each contested grant and is unchanged otherwise.
REQ-027 loopback_interface_ready SHALL equal network grant; FIFO pop SHALL equal loopback grant; at most one grant per cycle.
REQ-028 Latency: network message accepted at edge N SHALL be valid to core after edge N; local send accepted at edge N with empty FIFO and free output SHALL be valid to core after edge N+1.
REQ-029 While out_valid and !core_interceptor_ready, interceptor_core_data SHALL hold stable.
REQ-030 Message order within each source SHALL be preserved; no message SHALL be dropped or duplicated.

Reset
REQ-031 While rst is high: out_valid=0, FIFO count/pointers=0, prio=0, interceptor_core_valid=0, loopback_interface_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO and output register contents immediately, asynchronously.
REQ-033 Pass-through outputs (REQ-018) SHALL remain combinational during reset; local-send ready SHALL be 1 (FIFO empty).

Verification
REQ-034 local_address=5; send dst=3, tag=1, data=0x11, adapter ready=1 -> loopback_interface_valid=1 same cycle, data identical, FIFO count stays 0.
REQ-035 Send dst=5, tag=2, data=0xAB, core ready=1, no network traffic -> interceptor_core_valid=1 two edges later, meta.address=5, tag=2, data=0xAB.
REQ-036 Core receive ready=0, DEPTH=2, four local sends -> first in output reg, next two in FIFO, interceptor_core_ready=0 for the fourth until the core drains.
REQ-037 Network and loopback continuously valid, core ready=1, from reset -> core sees network, loopback, network, loopback in that order.
REQ-038 Output valid with core ready=0 for 3 cycles -> data stable, loopback_interface_ready=0; assert rst mid-stream -> interceptor_core_valid=0 with no clock edge.
